// File: rtl/scan_sequencer.sv
// Pixel/line/frame timing sequencer for the galvo scan path (clk_adc domain).
// A free-running pixel counter drives the pixel tick, galvo strobes, AWG sync and the sampling gate.
module scan_sequencer #(
  parameter int CNT_W     = 12,
  parameter int PIX_W     = 11,
  parameter int LINE_W    = 11,
  parameter int FRM_W     = 8,
  parameter int GO_LOG2   = 1,
  parameter int SYNC_DIV  = 2,
  parameter int PIXEL_DEF = 1000
) (
  input  logic              clk_adc,
  input  logic              rst_adc_n,
  input  logic              run,
  input  logic              halt,
  input  logic [1:0]        mode,
  input  logic [FRM_W-1:0]  frame_count,
  input  logic [CNT_W-1:0]  pixel_size,
  input  logic [PIX_W-1:0]  pixels_per_line,
  input  logic [LINE_W-1:0] lines_per_frame,
  output logic              sampling,
  output logic              last,
  output logic              galvo_go,
  output logic              line_end,
  output logic              frame_end,
  output logic              sync_awg,
  output logic              done,
  output logic              busy,
  output logic [PIX_W-1:0]  pix_idx,
  output logic [LINE_W-1:0] line_idx
);

  localparam int SYNC_W = (SYNC_DIV > 1) ? $clog2(SYNC_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DRAIN} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_p;
  logic [1:0]          r_mode;
  logic [FRM_W-1:0]    r_n;
  logic [PIX_W-1:0]    r_l;
  logic [LINE_W-1:0]   r_f;
  logic [PIX_W-1:0]    r_pix;
  logic [LINE_W-1:0]   r_line;
  logic [FRM_W-1:0]    r_frm;
  logic [SYNC_W-1:0]   r_sync;
  logic                r_sampling;
  logic                r_busy;
  logic                r_last;
  logic                r_galvo_go;
  logic                r_line_end;
  logic                r_frame_end;
  logic                r_sync_awg;
  logic                r_done;

  logic                w_bnd;
  logic                w_go_hit;
  logic                w_active;
  logic [CNT_W-1:0]    w_step;
  logic [CNT_W-1:0]    w_p_clamped;
  logic                w_pix_wrap;
  logic                w_line_wrap;
  logic [FRM_W-1:0]    w_frm_nxt;
  logic                w_complete;
  logic [SYNC_W-1:0]   w_sync_nxt;

  assign w_bnd       = (r_cnt == r_p - CNT_W'(1));
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_step      = r_p >> GO_LOG2;
  assign w_p_clamped = (pixel_size < CNT_W'(4)) ? CNT_W'(4) : pixel_size;
  assign w_pix_wrap  = (r_pix == r_l - PIX_W'(1));
  assign w_line_wrap = w_pix_wrap && (r_line == r_f - LINE_W'(1));
  assign w_frm_nxt   = r_frm + FRM_W'(1);
  assign w_complete  = w_line_wrap &&
                       ((r_mode == 2'd1) || ((r_mode == 2'd2) && (w_frm_nxt == r_n)));
  assign w_sync_nxt  = (r_sync == SYNC_W'(SYNC_DIV - 1)) ? '0 : r_sync + SYNC_W'(1);

  // Galvo steps split the pixel into 2^GO_LOG2 equal slices; the last slice ends on the boundary.
  // NOTE: w_go_hit gets a default before the loop so no latch is inferred.
  always_comb begin
    w_go_hit = w_bnd;
    for (int k = 1; k < (1 << GO_LOG2); k++) begin
      if (r_cnt == CNT_W'(k) * w_step - CNT_W'(1)) w_go_hit = 1'b1;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p         <= CNT_W'(PIXEL_DEF);
      r_mode      <= '0;
      r_n         <= '0;
      r_l         <= '0;
      r_f         <= '0;
      r_pix       <= '0;
      r_line      <= '0;
      r_frm       <= '0;
      r_sync      <= '0;
      r_sampling  <= 1'b0;
      r_busy      <= 1'b0;
      r_last      <= 1'b0;
      r_galvo_go  <= 1'b0;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
      r_sync_awg  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt       <= w_bnd ? '0 : r_cnt + CNT_W'(1);
      r_last      <= w_bnd;
      r_galvo_go  <= w_go_hit && w_active;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
      r_sync_awg  <= 1'b0;
      r_done      <= 1'b0;

      if (w_bnd && !w_active) r_p <= w_p_clamped;

      case (r_state)
        S_IDLE: begin
          if (run && !halt) begin
            r_state <= S_ARMED;
            r_busy  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (halt) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_bnd) begin
            r_state    <= S_RUN;
            r_sampling <= 1'b1;
            r_mode     <= mode;
            r_n        <= (frame_count == '0) ? FRM_W'(1) : frame_count;
            r_l        <= (pixels_per_line == '0) ? PIX_W'(1) : pixels_per_line;
            r_f        <= (lines_per_frame == '0) ? LINE_W'(1) : lines_per_frame;
            r_pix      <= '0;
            r_line     <= '0;
            r_frm      <= '0;
            r_sync     <= '0;
            r_sync_awg <= 1'b1;
          end
        end
        S_RUN, S_DRAIN: begin
          if (w_bnd) begin
            r_pix <= w_pix_wrap ? '0 : r_pix + PIX_W'(1);
            if (w_pix_wrap) begin
              r_line_end <= 1'b1;
              r_line     <= w_line_wrap ? '0 : r_line + LINE_W'(1);
            end
            if (w_line_wrap) begin
              r_frame_end <= 1'b1;
              r_frm       <= w_frm_nxt;
            end
            // A halt landing exactly on the boundary stops here rather than draining a full extra pixel.
            if ((r_state == S_DRAIN) || halt || w_complete) begin
              r_state    <= S_IDLE;
              r_sampling <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= w_complete && (r_state == S_RUN);
            end else begin
              r_sync     <= w_sync_nxt;
              r_sync_awg <= (w_sync_nxt == '0);
            end
          end else if ((r_state == S_RUN) && halt) begin
            r_state <= S_DRAIN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sampling  = r_sampling;
  assign busy      = r_busy;
  assign last      = r_last;
  assign galvo_go  = r_galvo_go;
  assign line_end  = r_line_end;
  assign frame_end = r_frame_end;
  assign sync_awg  = r_sync_awg;
  assign done      = r_done;
  assign pix_idx   = r_pix;
  assign line_idx  = r_line;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: timing sequences on hand-computed cycle offsets
// plus a table of complete scans compared against hand-computed event counts.
module tb_scan_sequencer;

  logic        clk_adc = 1'b0;
  logic        rst_adc_n;
  logic        run;
  logic        halt;
  logic [1:0]  mode;
  logic [7:0]  frame_count;
  logic [11:0] pixel_size;
  logic [10:0] pixels_per_line;
  logic [10:0] lines_per_frame;
  logic        sampling, last, galvo_go, line_end, frame_end, sync_awg, done, busy;
  logic [10:0] pix_idx;
  logic [10:0] line_idx;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [11:0] ps;
    logic [10:0] l;
    logic [10:0] f;
    logic [1:0]  md;
    logic [7:0]  n;
    int          exp_samp;
    int          exp_le;
    int          exp_fe;
    int          exp_done;
    int          exp_go;
  } vec_t;

  vec_t vecs [5];

  scan_sequencer #(
    .CNT_W(12), .PIX_W(11), .LINE_W(11), .FRM_W(8),
    .GO_LOG2(1), .SYNC_DIV(2), .PIXEL_DEF(8)
  ) dut (
    .clk_adc(clk_adc), .rst_adc_n(rst_adc_n), .run(run), .halt(halt),
    .mode(mode), .frame_count(frame_count), .pixel_size(pixel_size),
    .pixels_per_line(pixels_per_line), .lines_per_frame(lines_per_frame),
    .sampling(sampling), .last(last), .galvo_go(galvo_go), .line_end(line_end),
    .frame_end(frame_end), .sync_awg(sync_awg), .done(done), .busy(busy),
    .pix_idx(pix_idx), .line_idx(line_idx)
  );

  always #5 clk_adc = ~clk_adc;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_adc);
  endtask

  // Leaves the bench on the negedge where last is high, i.e. the first cycle of a pixel (cnt == 0).
  task automatic align();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last && n < 100);
    if (!last) check("align_timeout", 0, 1);
  endtask

  task automatic measure_period(input string name, input int exp);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last && n < 100);
    check(name, n, exp);
  endtask

  task automatic configure(input logic [11:0] ps, input logic [10:0] l, input logic [10:0] f,
                           input logic [1:0] md, input logic [7:0] n);
    pixel_size      = ps;
    pixels_per_line = l;
    lines_per_frame = f;
    mode            = md;
    frame_count     = n;
  endtask

  initial begin
    int samp, le, fe, dn, go, fe_at_done, cyc, tail;
    logic seen;

    vecs[0] = '{ps: 12'd8, l: 11'd4, f: 11'd2, md: 2'd1, n: 8'd0,
                exp_samp: 64, exp_le: 2, exp_fe: 1, exp_done: 1, exp_go: 16};
    vecs[1] = '{ps: 12'd8, l: 11'd2, f: 11'd1, md: 2'd2, n: 8'd3,
                exp_samp: 48, exp_le: 3, exp_fe: 3, exp_done: 1, exp_go: 12};
    vecs[2] = '{ps: 12'd2, l: 11'd3, f: 11'd2, md: 2'd1, n: 8'd0,
                exp_samp: 24, exp_le: 2, exp_fe: 1, exp_done: 1, exp_go: 12};
    vecs[3] = '{ps: 12'd5, l: 11'd0, f: 11'd0, md: 2'd2, n: 8'd0,
                exp_samp: 5, exp_le: 1, exp_fe: 1, exp_done: 1, exp_go: 2};
    vecs[4] = '{ps: 12'd6, l: 11'd1, f: 11'd3, md: 2'd2, n: 8'd2,
                exp_samp: 36, exp_le: 6, exp_fe: 2, exp_done: 1, exp_go: 12};

    rst_adc_n = 1'b0;
    run = 1'b0;
    halt = 1'b0;
    configure(12'd8, 11'd4, 11'd2, 2'd1, 8'd0);
    repeat (3) tick();
    rst_adc_n = 1'b1;
    check("rst_sampling", sampling, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
    check("rst_pix_idx", pix_idx, 0);
    check("rst_line_idx", line_idx, 0);

    // Idle: pixel tick every 8 cycles, no galvo strobes, no sampling.
    align();
    measure_period("idle_last_period", 8);
    go = 0;
    samp = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      go += int'(galvo_go);
      samp += int'(sampling);
    end
    check("idle_galvo_count", go, 0);
    check("idle_sampling_count", samp, 0);

    // Single frame, P=8, L=4, F=2: exact cycle timing from a run pulse at cnt == 0.
    configure(12'd8, 11'd4, 11'd2, 2'd1, 8'd0);
    align();
    run = 1'b1;
    for (int t = 1; t <= 72; t++) begin
      tick();
      if (t == 1) run = 1'b0;
      case (t)
        1:  check("c_busy_armed", busy, 1);
        7:  check("c_sampling_pre", sampling, 0);
        8: begin
          check("c_sampling_rise", sampling, 1);
          check("c_sync_entry", sync_awg, 1);
          check("c_galvo_entry", galvo_go, 0);
          check("c_pix0", pix_idx, 0);
        end
        11: check("c_galvo_cnt2", galvo_go, 0);
        12: check("c_galvo_cnt3", galvo_go, 1);
        16: begin
          check("c_galvo_cnt7", galvo_go, 1);
          check("c_pix1", pix_idx, 1);
          check("c_sync_pix1", sync_awg, 0);
        end
        24: begin
          check("c_sync_pix2", sync_awg, 1);
          check("c_pix2", pix_idx, 2);
        end
        40: begin
          check("c_line_end", line_end, 1);
          check("c_line_idx1", line_idx, 1);
          check("c_pix_wrap", pix_idx, 0);
        end
        71: check("c_done_early", done, 0);
        72: begin
          check("c_frame_end", frame_end, 1);
          check("c_done", done, 1);
          check("c_sampling_fall", sampling, 0);
          check("c_busy_fall", busy, 0);
        end
        default: ;
      endcase
    end

    // Continuous mode with halt at cnt 2 of the fifth pixel; pixel_size changed mid-run.
    configure(12'd8, 11'd16, 11'd4, 2'd0, 8'd0);
    align();
    run = 1'b1;
    dn = 0;
    for (int t = 1; t <= 68; t++) begin
      tick();
      if (t == 1) run = 1'b0;
      dn += int'(done);
      case (t)
        8:  check("d_sampling_rise", sampling, 1);
        20: pixel_size = 12'd12;
        24: check("d_period_frozen", last, 1);
        42: halt = 1'b1;
        43: begin
          halt = 1'b0;
          check("d_busy_drain", busy, 1);
          check("d_sampling_drain", sampling, 1);
        end
        47: check("d_sampling_last_cycle", sampling, 1);
        48: begin
          check("d_sampling_off", sampling, 0);
          check("d_busy_off", busy, 0);
          check("d_pix_idx5", pix_idx, 5);
          check("d_last_at_stop", last, 1);
        end
        56: check("d_idle_old_period", last, 1);
        64: check("d_idle_no_tick", last, 0);
        68: check("d_idle_new_period", last, 1);
        default: ;
      endcase
    end
    check("d_no_done", dn, 0);

    // run+halt together from IDLE, then halt while ARMED.
    pixel_size = 12'd8;
    align();
    align();
    run = 1'b1;
    halt = 1'b1;
    tick();
    check("e_run_halt_idle", busy, 0);
    halt = 1'b0;
    tick();
    check("e_armed", busy, 1);
    run = 1'b0;
    halt = 1'b1;
    tick();
    check("e_halt_armed", busy, 0);
    halt = 1'b0;
    samp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      samp += int'(sampling);
    end
    check("e_never_sampled", samp, 0);

    // Clamp: pixel_size 2 becomes a 4-cycle pixel.
    pixel_size = 12'd2;
    align();
    align();
    measure_period("f_clamp_period_a", 4);
    measure_period("f_clamp_period_b", 4);

    // Complete scans against hand-computed event counts.
    for (int v = 0; v < 5; v++) begin
      configure(vecs[v].ps, vecs[v].l, vecs[v].f, vecs[v].md, vecs[v].n);
      tick();
      run = 1'b1;
      tick();
      run = 1'b0;
      samp = 0; le = 0; fe = 0; dn = 0; go = 0; fe_at_done = -1;
      cyc = 0; tail = 0; seen = 1'b0;
      while (tail < 3 && cyc < 3000) begin
        tick();
        cyc++;
        samp += int'(sampling);
        le   += int'(line_end);
        fe   += int'(frame_end);
        go   += int'(galvo_go);
        if (done) begin
          dn++;
          fe_at_done = fe;
        end
        if (busy) seen = 1'b1;
        if (seen && !busy) tail++;
      end
      if (cyc >= 3000) check($sformatf("v%0d_timeout", v), cyc, 0);
      check($sformatf("v%0d_sampled_cycles", v), samp, vecs[v].exp_samp);
      check($sformatf("v%0d_line_end", v), le, vecs[v].exp_le);
      check($sformatf("v%0d_frame_end", v), fe, vecs[v].exp_fe);
      check($sformatf("v%0d_done", v), dn, vecs[v].exp_done);
      check($sformatf("v%0d_galvo", v), go, vecs[v].exp_go);
      check($sformatf("v%0d_fe_at_done", v), fe_at_done, vecs[v].exp_fe);
    end

    // Reset in the middle of a frame aborts without done or frame_end.
    configure(12'd8, 11'd4, 11'd2, 2'd1, 8'd0);
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (30) tick();
    check("g_sampling_before_reset", sampling, 1);
    rst_adc_n = 1'b0;
    #1;
    check("g_reset_sampling", sampling, 0);
    check("g_reset_busy", busy, 0);
    check("g_reset_pix_idx", pix_idx, 0);
    tick();
    rst_adc_n = 1'b1;
    dn = 0;
    fe = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      dn += int'(done);
      fe += int'(frame_end);
    end
    check("g_no_done", dn, 0);
    check("g_no_frame_end", fe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
